temp_sensor_frontend: RTL
=========================

Name: temp_sensor_frontend

Overview:
- Upstream stage of the smart-home climate path.
- Polls an external serial temperature sensor, rejects faulty samples, and averages over a sliding window.
- Produces the 5-bit temperature bus that the AC controller consumes, in 1 °C/LSB, saturated to 0..31.
- Sits between the board sensor pins and the AC block inside the Smart_Home top.

Parameters:
- CLK_DIV, 4: clk cycles per sensor_sclk half-period (must be ≥ 1).
- SAMPLE_PERIOD, 1000: clk cycles between conversion starts (must be > 18*CLK_DIV + 2).
- AVG_LOG2, 2: log2 of averaging window depth (window = 4 samples).
- RESET_TEMP, 20: temperature output value from reset until the first average is ready (keeps AC idle).

Ports:
- clk  input  1  system clock
- rst  input  1  asynchronous, active-high reset
- sensor_sdo  input  1  serial data from sensor, MSB first
- sensor_sclk  output  1  serial clock to sensor, idle low
- sensor_cs_n  output  1  sensor chip select, active low, idle high
- temperature  output  5  averaged, saturated temperature, 1 °C/LSB
- temp_valid  output  1  one-cycle pulse when temperature is updated
- sensor_fault  output  1  high while the last sample was invalid

Behaviour:
- Reset: one clock (clk); reset is asynchronous and active-high (rst). Asserting rst forces the following immediately, at any time, including mid-transfer:
  - sensor_cs_n=1, sensor_sclk=0.
  - temperature=RESET_TEMP, temp_valid=0, sensor_fault=0.
  - Period counter=0, window cleared, fill count=0, FSM=IDLE.
- Period counter: free-runs 0..SAMPLE_PERIOD-1, then wraps. A conversion starts in any cycle where the counter is 0 and the FSM is IDLE. The first start is on the first clk edge after rst deasserts.
- FSM states:
  - IDLE: cs_n=1, sclk=0. Goes to SELECT on start.
  - SELECT: cs_n=0, sclk=0, held for CLK_DIV cycles. Then goes to SHIFT.
  - SHIFT: 8 bits. Each bit drives sclk low for CLK_DIV cycles, then high for CLK_DIV cycles. sdo is captured into the shift register on the clk edge where sclk goes 0→1, MSB first. After the 8th high phase, goes to DESELECT.
  - DESELECT: cs_n=1, sclk=0, held for CLK_DIV cycles. Then goes to UPDATE.
  - UPDATE: one cycle to process the sample. Then goes to IDLE.
- Latency: start to temp_valid = CLK_DIV + 16*CLK_DIV + CLK_DIV + 1 cycles (73 with defaults).
- Sample check (in UPDATE), applied to the 8-bit unsigned sample:
  - Invalid if 8'h00 or 8'hFF (open/stuck line). In that case: sensor_fault=1, the sample is discarded, the window is unchanged, temperature holds, and no temp_valid.
  - Otherwise valid: sensor_fault=0, and the sample is pushed into the window, replacing the oldest entry.
- Averaging:
  - Fill count saturates at 2^AVG_LOG2.
  - While the window is not full, temperature stays RESET_TEMP and temp_valid stays 0.
  - Once full, each valid sample does the following:
    - sum = sum of all window entries, in 8+AVG_LOG2 bits with no overflow.
    - avg = sum >> AVG_LOG2, truncating.
    - temperature = (avg > 31) ? 31 : avg[4:0].
    - temp_valid pulses high for exactly one cycle, coincident with the new temperature value.
- temperature and temp_valid are registered outputs and change only on the UPDATE edge.
- A fault does not flush the window. The next valid sample resumes averaging at once if the window is full.
- Period counter reaches 0 while the FSM is not IDLE: that start is skipped, with no queuing.
- sensor_sdo is sampled only in SHIFT; its value at all other times is ignored.

Decomposition:
- smart_home_pkg holds:
  - TEMP_W=5 and SAMPLE_W=8.
  - The FSM state enum: IDLE, SELECT, SHIFT, DESELECT, UPDATE.
  - Constants SAMPLE_INVALID_LO=8'h00 and SAMPLE_INVALID_HI=8'hFF.
  - TEMP_MAX=31.
- One sub-module, sensor_spi_rx, is natural. It contains:
  - The SELECT/SHIFT/DESELECT sequencing.
  - The sclk divider.
  - The shift register.
  - Outputs sample[7:0] and a one-cycle sample_done.
- temp_sensor_frontend keeps the period counter, fault check, window, averaging, and saturation.

Test Plan:
- Reset then idle sensor: rst high 3 cycles, then low. Required:
  - cs_n falls on the first edge after rst deasserts.
  - Exactly 8 sclk pulses, each high for 4 clk cycles.
  - temperature=20 and no temp_valid until the 4th valid sample.
- Steady samples: sensor returns 8'd22 for four conversions. Required: temperature=22 with one temp_valid pulse 73 cycles after the 4th start; the pulse recurs every 1000 cycles.
- Averaging and truncation: samples 20, 21, 21, 23 (sum 85). Required: temperature=21. The next sample 27 (window 21, 21, 23, 27, sum 92) gives temperature=23.
- Saturation: four samples of 8'd200. Required: temperature=31. A following sample of 8'd10 gives (200*3+10)>>2=152, so temperature stays 31.
- Fault: with a full window at 22, the sensor returns 8'hFF. Required: sensor_fault=1, temperature stays 22, no temp_valid. The next sample 22 clears sensor_fault and pulses temp_valid with temperature=22.
- Reset mid-SHIFT: assert rst after 3 bits shifted. Required: cs_n=1 and sclk=0 in the same cycle, without waiting for clk. temperature=20. The window is empty, so 4 new valid samples are needed before the next temp_valid.

Source files
------------

// File: rtl/smart_home_pkg.sv
// rtl/smart_home_pkg.sv - shared widths, sample limits and sensor FSM states for the climate path
package smart_home_pkg;

    localparam int TEMP_W   = 5;
    localparam int SAMPLE_W = 8;
    localparam int TEMP_MAX = 31;

    localparam logic [SAMPLE_W-1:0] SAMPLE_INVALID_LO = 8'h00;
    localparam logic [SAMPLE_W-1:0] SAMPLE_INVALID_HI = 8'hFF;

    typedef enum logic [2:0] {
        IDLE,
        SELECT,
        SHIFT,
        DESELECT,
        UPDATE
    } state_t;

    // All-zeros or all-ones means an open or stuck data line.
    function automatic logic sample_is_valid(input logic [SAMPLE_W-1:0] s);
        return (s != SAMPLE_INVALID_LO) && (s != SAMPLE_INVALID_HI);
    endfunction

endpackage

// File: rtl/sensor_spi_rx.sv
// rtl/sensor_spi_rx.sv - serial sensor read: chip select, divided sclk, 8-bit MSB-first capture
module sensor_spi_rx
    import smart_home_pkg::*;
#(
    parameter int CLK_DIV = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start_i,
    input  logic                sdo_i,
    output logic                sclk_o,
    output logic                cs_n_o,
    output logic                busy_o,
    output logic [SAMPLE_W-1:0] sample_o,
    output logic                sample_done_o
);

    localparam int             DW       = $clog2(CLK_DIV + 1);
    localparam logic [DW-1:0]  DIV_LAST = DW'(CLK_DIV - 1);
    localparam logic [2:0]     BIT_LAST = 3'(SAMPLE_W - 1);

    state_t                state_q;
    logic [DW-1:0]         div_q;
    logic [2:0]            bit_q;
    logic [SAMPLE_W-1:0]   shift_q;
    logic                  sclk_q;
    logic                  cs_n_q;
    logic                  done_q;
    logic                  div_end;

    assign div_end = (div_q == DIV_LAST);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            div_q   <= '0;
            bit_q   <= '0;
            shift_q <= '0;
            sclk_q  <= 1'b0;
            cs_n_q  <= 1'b1;
            done_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (start_i) begin
                        state_q <= SELECT;
                        cs_n_q  <= 1'b0;
                        div_q   <= '0;
                    end
                end
                SELECT: begin
                    if (div_end) begin
                        state_q <= SHIFT;
                        div_q   <= '0;
                        bit_q   <= '0;
                    end else begin
                        div_q <= div_q + 1'b1;
                    end
                end
                SHIFT: begin
                    if (!div_end) begin
                        div_q <= div_q + 1'b1;
                    end else begin
                        div_q  <= '0;
                        sclk_q <= ~sclk_q;
                        // Capture on the edge that raises sclk; the bit count advances on the fall.
                        if (!sclk_q) begin
                            shift_q <= {shift_q[SAMPLE_W-2:0], sdo_i};
                        end else if (bit_q == BIT_LAST) begin
                            state_q <= DESELECT;
                            cs_n_q  <= 1'b1;
                        end else begin
                            bit_q <= bit_q + 1'b1;
                        end
                    end
                end
                DESELECT: begin
                    if (div_end) begin
                        state_q <= UPDATE;
                        div_q   <= '0;
                        done_q  <= 1'b1;
                    end else begin
                        div_q <= div_q + 1'b1;
                    end
                end
                UPDATE:  state_q <= IDLE;
                default: state_q <= IDLE;
            endcase
        end
    end

    assign sclk_o        = sclk_q;
    assign cs_n_o        = cs_n_q;
    assign busy_o        = (state_q != IDLE);
    assign sample_o      = shift_q;
    assign sample_done_o = done_q;

endmodule

// File: rtl/temp_sensor_frontend.sv
// rtl/temp_sensor_frontend.sv - periodic sensor poll, fault rejection, sliding-window average, saturation
module temp_sensor_frontend
    import smart_home_pkg::*;
#(
    parameter int CLK_DIV       = 4,
    parameter int SAMPLE_PERIOD = 1000,
    parameter int AVG_LOG2      = 2,
    parameter int RESET_TEMP    = 20
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              sensor_sdo,
    output logic              sensor_sclk,
    output logic              sensor_cs_n,
    output logic [TEMP_W-1:0] temperature,
    output logic              temp_valid,
    output logic              sensor_fault
);

    localparam int                DEPTH = 1 << AVG_LOG2;
    localparam int                CW    = $clog2(SAMPLE_PERIOD);
    localparam int                SUM_W = SAMPLE_W + AVG_LOG2;
    localparam logic [AVG_LOG2:0] FULL  = (AVG_LOG2 + 1)'(DEPTH);

    logic [CW-1:0]       cnt_q, cnt_d;
    logic                busy;
    logic                start;
    logic                sample_done;
    logic                sample_ok;
    logic [SAMPLE_W-1:0] sample;
    logic [SAMPLE_W-1:0] win_q [DEPTH];
    logic [AVG_LOG2-1:0] ptr_q;
    logic [AVG_LOG2:0]   fill_q, fill_d;
    logic [SUM_W-1:0]    sum_d;
    logic [SAMPLE_W-1:0] avg_d;
    logic [TEMP_W-1:0]   temp_q, temp_d;
    logic                valid_q;
    logic                fault_q;

    sensor_spi_rx #(
        .CLK_DIV (CLK_DIV)
    ) u_spi_rx (
        .clk           (clk),
        .rst           (rst),
        .start_i       (start),
        .sdo_i         (sensor_sdo),
        .sclk_o        (sensor_sclk),
        .cs_n_o        (sensor_cs_n),
        .busy_o        (busy),
        .sample_o      (sample),
        .sample_done_o (sample_done)
    );

    assign cnt_d     = (cnt_q == CW'(SAMPLE_PERIOD - 1)) ? '0 : cnt_q + 1'b1;
    assign start     = (cnt_q == '0) && !busy;
    assign sample_ok = sample_is_valid(sample);
    assign fill_d    = (fill_q == FULL) ? fill_q : fill_q + 1'b1;

    // Sum of the window as it will be once the incoming sample replaces the oldest slot.
    always_comb begin
        sum_d = '0;
        for (int i = 0; i < DEPTH; i++) begin
            sum_d = sum_d + SUM_W'((AVG_LOG2'(i) == ptr_q) ? sample : win_q[i]);
        end
        avg_d  = sum_d[SUM_W-1:AVG_LOG2];
        temp_d = (avg_d > SAMPLE_W'(TEMP_MAX)) ? TEMP_W'(TEMP_MAX) : avg_d[TEMP_W-1:0];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q   <= '0;
            ptr_q   <= '0;
            fill_q  <= '0;
            temp_q  <= TEMP_W'(RESET_TEMP);
            valid_q <= 1'b0;
            fault_q <= 1'b0;
            for (int i = 0; i < DEPTH; i++) begin
                win_q[i] <= '0;
            end
        end else begin
            cnt_q   <= cnt_d;
            valid_q <= 1'b0;
            if (sample_done) begin
                fault_q <= !sample_ok;
                if (sample_ok) begin
                    win_q[ptr_q] <= sample;
                    ptr_q        <= ptr_q + 1'b1;
                    fill_q       <= fill_d;
                    if (fill_d == FULL) begin
                        temp_q  <= temp_d;
                        valid_q <= 1'b1;
                    end
                end
            end
        end
    end

    assign temperature  = temp_q;
    assign temp_valid   = valid_q;
    assign sensor_fault = fault_q;

endmodule
